// File: rtl/lenet_pkg.sv
// Shared LeNet-5 pipeline definitions: image geometry defaults, window state
// encoding and the flat-window slice index helper.
package lenet_pkg;

    localparam int IMG_W      = 32;
    localparam int IMG_H      = 32;
    localparam int K          = 5;
    localparam int PIXELWIDTH = 8;

    typedef enum logic {
        PRIME  = 1'b0,
        ACTIVE = 1'b1
    } win_state_e;

    // Bit offset of window element (r,c) inside a flat K*K*pw vector.
    function automatic int win_idx(input int r, input int c, input int k, input int pw);
        return (r * k + c) * pw;
    endfunction

endpackage

// File: rtl/line_delay.sv
// One image row of pixel delay: a circular buffer whose read tap returns the
// pixel accepted DEPTH enables ago.
module line_delay #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    ptr_r;

    // Read/write pointer, advanced once per accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if (en) begin
            ptr_r <= (ptr_r == PTR_LAST) ? '0 : ptr_r + AW'(1'b1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Storage is left unreset: every slot is rewritten before it is observed.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_r[ptr_r] <= din;
        end
    end

    assign dout = mem_r[ptr_r];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream to K x K sliding-window generator feeding the C1 convolution
// stage; buffers K-1 rows and emits one complete window per accepted pixel.
module conv_window_gen #(
    parameter int IMG_W      = lenet_pkg::IMG_W,
    parameter int IMG_H      = lenet_pkg::IMG_H,
    parameter int K          = lenet_pkg::K,
    parameter int PIXELWIDTH = lenet_pkg::PIXELWIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_sof,
    input  logic [PIXELWIDTH-1:0]           in_pixel,
    output logic                            out_valid,
    output logic [K*K*PIXELWIDTH-1:0]       out_window,
    output logic [$clog2(IMG_H)-1:0]        out_row,
    output logic [$clog2(IMG_W)-1:0]        out_col,
    output logic                            frame_done
);
    import lenet_pkg::*;

    localparam int RW  = $clog2(IMG_H);
    localparam int CW  = $clog2(IMG_W);
    localparam int ROWW = K * PIXELWIDTH;
    localparam logic [CW-1:0] COL_LAST       = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST       = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PRIME_LAST = RW'(K - 2);
    localparam logic [RW-1:0] ROW_OFS        = RW'(K - 1);

    logic [PIXELWIDTH-1:0] line_in_s [K-1];
    logic [PIXELWIDTH-1:0] tap_s     [K-1];
    logic [PIXELWIDTH-1:0] col_in_s  [K];

    win_state_e        state_r, state_next_s, eff_state_s;
    logic [CW-1:0]     col_r, col_next_s, eff_col_s;
    logic [RW-1:0]     row_r, row_next_s, eff_row_s;
    logic              last_col_s, last_row_s, emit_s;
    logic [K*ROWW-1:0] win_r, win_next_s;
    logic              out_valid_r, frame_done_r;
    logic [RW-1:0]     out_row_r;
    logic [CW-1:0]     out_col_r;

    // Row delay chain: tap g holds the pixel g+1 rows above the incoming one.
    for (genvar g = 0; g < K - 1; g++) begin : g_line
        if (g == 0) begin : g_head
            assign line_in_s[g] = in_pixel;
        end else begin : g_link
            assign line_in_s[g] = tap_s[g-1];
        end
        line_delay #(.DEPTH(IMG_W), .WIDTH(PIXELWIDTH)) u_line (
            .clk  (clk),
            .rst  (rst),
            .en   (in_valid),
            .din  (line_in_s[g]),
            .dout (tap_s[g])
        );
    end

    for (genvar r = 0; r < K; r++) begin : g_col_in
        if (r == K - 1) begin : g_new
            assign col_in_s[r] = in_pixel;
        end else begin : g_tap
            assign col_in_s[r] = tap_s[K-2-r];
        end
    end

    // Effective position of the current pixel; start-of-frame forces (0,0).
    always_comb begin
        eff_col_s   = in_sof ? '0 : col_r;
        eff_row_s   = in_sof ? '0 : row_r;
        eff_state_s = in_sof ? PRIME : state_r;
        last_col_s  = (eff_col_s == COL_LAST);
        last_row_s  = (eff_row_s == ROW_LAST);
        emit_s      = in_valid && (eff_state_s == ACTIVE) && (eff_col_s >= COL_FIRST_WIN);
        col_next_s  = last_col_s ? '0 : eff_col_s + CW'(1'b1);
        row_next_s  = eff_row_s;
        if (last_col_s) begin
            row_next_s = last_row_s ? '0 : eff_row_s + RW'(1'b1);
        end else begin
            row_next_s = eff_row_s;
        end
    end

    // PRIME/ACTIVE transitions happen only at the end of a row.
    always_comb begin
        state_next_s = state_r;
        if (in_valid && last_col_s) begin
            case (eff_state_s)
                PRIME:   state_next_s = (eff_row_s == ROW_PRIME_LAST) ? ACTIVE : PRIME;
                ACTIVE:  state_next_s = last_row_s ? PRIME : ACTIVE;
                default: state_next_s = PRIME;
            endcase
        end else if (in_valid) begin
            state_next_s = eff_state_s;
        end else begin
            state_next_s = state_r;
        end
    end

    // Each window row shifts one column left; the new right column enters at c=K-1.
    always_comb begin
        win_next_s = win_r;
        for (int r = 0; r < K; r++) begin
            win_next_s[win_idx(r, 0, K, PIXELWIDTH) +: ROWW] =
                {col_in_s[r], win_r[win_idx(r, 1, K, PIXELWIDTH) +: ROWW - PIXELWIDTH]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= PRIME;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Position counters and window array; everything freezes while in_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r <= '0;
            row_r <= '0;
            win_r <= '0;
        end else if (in_valid) begin
            col_r <= col_next_s;
            row_r <= row_next_s;
            win_r <= win_next_s;
        end else begin
            col_r <= col_r;
            row_r <= row_r;
            win_r <= win_r;
        end
    end

    // Registered window strobe, end-of-frame pulse and top-left coordinates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            out_row_r    <= '0;
            out_col_r    <= '0;
        end else if (emit_s) begin
            out_valid_r  <= 1'b1;
            frame_done_r <= last_col_s && last_row_s;
            out_row_r    <= eff_row_s - ROW_OFS;
            out_col_r    <= eff_col_s - COL_FIRST_WIN;
        end else begin
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            out_row_r    <= out_row_r;
            out_col_r    <= out_col_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign frame_done = frame_done_r;
    assign out_row    = out_row_r;
    assign out_col    = out_col_r;
    assign out_window = win_r;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: ramp frames, gapped input, back-to-back
// frames, mid-frame restart and mid-frame reset, checked against a ramp model.
module tb_conv_window_gen;

    localparam int WW = 200;

    typedef struct {
        int row;
        int col;
        int off;
        bit fd;
    } exp_t;

    typedef struct {
        int idx;
        int row;
        int col;
        int tl;
        int br;
        int fd;
        int acc;
    } probe_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [7:0]    in_pixel = 8'h00;
    logic          out_valid;
    logic [WW-1:0] out_window;
    logic [4:0]    out_row;
    logic [4:0]    out_col;
    logic          frame_done;

    conv_window_gen dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    exp_t          e_cur;
    logic [WW-1:0] e_win;
    logic [WW-1:0] cap_win [2048];
    logic [WW-1:0] ref_win [784];
    int            cap_acc [2048];
    int            cap_row [2048];
    int            cap_col [2048];
    int            cap_fd  [2048];
    int            n_cap = 0;
    int            acc_cnt = 0;
    int            fd_cnt = 0;
    int            max_col = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            iv_prev = 1'b0;
    probe_t        probes [5];

    function automatic logic [WW-1:0] model(input int wr, input int wc, input int off);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w[(r*5+c)*8 +: 8] = 8'(((wr + r) * 32 + wc + c + off) & 255);
            end
        end
        return w;
    endfunction

    // Window monitor: every out_valid must match the next expected window.
    always @(negedge clk) begin
        if (rst && !out_valid && frame_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_done_alone: frame_done=1 with out_valid=0, required 0");
        end
        if (rst && out_valid) begin
            n_cmp++;
            if (!iv_prev) begin
                n_bad++;
                $display("FAIL valid_in_gap: out_valid=1 after a gap cycle, required 0");
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_window: got window at (%0d,%0d), required none", out_row, out_col);
            end else begin
                e_cur = exp_q.pop_front();
                e_win = model(e_cur.row, e_cur.col, e_cur.off);
                if ({out_row, out_col, frame_done, out_window} !== {5'(e_cur.row), 5'(e_cur.col), e_cur.fd, e_win}) begin
                    n_bad++;
                    $display("FAIL window: got (%0d,%0d) fd=%0b %h, required (%0d,%0d) fd=%0b %h",
                             out_row, out_col, frame_done, out_window, e_cur.row, e_cur.col, e_cur.fd, e_win);
                end
            end
            if (n_cap < 2048) begin
                cap_win[n_cap] = out_window;
                cap_acc[n_cap] = acc_cnt;
                cap_row[n_cap] = int'(out_row);
                cap_col[n_cap] = int'(out_col);
                cap_fd[n_cap]  = int'(frame_done);
            end
            n_cap++;
            if (frame_done) fd_cnt++;
            if (int'(out_col) > max_col) max_col = int'(out_col);
        end
        iv_prev = in_valid;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic pix(input logic v, input logic s, input logic [7:0] p);
        in_valid = v;
        in_sof   = s;
        in_pixel = p;
        @(posedge clk);
        #1;
        if (v) acc_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) pix(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic send(input int first, input int last, input int off, input bit sof0, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 9) >= 3) begin
                    pix(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                end
            end
            pix(1'b1, sof0 && (i == first), 8'((i + off) & 255));
        end
    endtask

    task automatic push_part(input int nwin, input int off);
        exp_t e;
        for (int k = 0; k < nwin; k++) begin
            e.row = k / 28;
            e.col = k % 28;
            e.off = off;
            e.fd  = (k == 783);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_stats();
        exp_q.delete();
        n_cap   = 0;
        acc_cnt = 0;
        fd_cnt  = 0;
        max_col = 0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_window_zero", int'(out_window == '0), 1);
        check("rst_coords", int'({out_row, out_col}), 0);
        rst = 1'b1;
        clear_stats();
    endtask

    initial begin
        probes[0] = '{idx: 0,   row: 0,  col: 0,  tl: 8'h00, br: 8'h84, fd: 0, acc: 133};
        probes[1] = '{idx: 27,  row: 0,  col: 27, tl: 8'h1B, br: 8'h9F, fd: 0, acc: 160};
        probes[2] = '{idx: 28,  row: 1,  col: 0,  tl: 8'h20, br: 8'hA4, fd: 0, acc: 165};
        probes[3] = '{idx: 782, row: 27, col: 26, tl: 8'h7A, br: 8'hFE, fd: 0, acc: 1023};
        probes[4] = '{idx: 783, row: 27, col: 27, tl: 8'h7B, br: 8'hFF, fd: 1, acc: 1024};

        // Continuous ramp frame.
        do_reset();
        push_part(784, 0);
        send(0, 1023, 0, 1'b0, 1'b0);
        idle(4);
        check("ramp_count", n_cap, 784);
        check("ramp_fd_count", fd_cnt, 1);
        check("ramp_max_col", max_col, 27);
        check("ramp_leftover", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("probe%0d_row", i), cap_row[probes[i].idx], probes[i].row);
            check($sformatf("probe%0d_col", i), cap_col[probes[i].idx], probes[i].col);
            check($sformatf("probe%0d_tl", i), int'(cap_win[probes[i].idx][7:0]), probes[i].tl);
            check($sformatf("probe%0d_br", i), int'(cap_win[probes[i].idx][199:192]), probes[i].br);
            check($sformatf("probe%0d_fd", i), cap_fd[probes[i].idx], probes[i].fd);
            check($sformatf("probe%0d_latency", i), cap_acc[probes[i].idx], probes[i].acc);
        end
        for (int i = 0; i < 784; i++) ref_win[i] = cap_win[i];

        // Same ramp with ~30% in_valid duty cycle.
        do_reset();
        push_part(784, 0);
        send(0, 1023, 0, 1'b0, 1'b1);
        idle(4);
        check("gap_count", n_cap, 784);
        begin
            int diffs;
            diffs = 0;
            for (int i = 0; i < 784; i++) begin
                if (cap_win[i] !== ref_win[i]) diffs++;
            end
            check("gap_vs_continuous_diffs", diffs, 0);
        end
        check("gap_leftover", exp_q.size(), 0);

        // Two back-to-back frames, second one offset by 1.
        do_reset();
        push_part(784, 0);
        push_part(784, 1);
        send(0, 1023, 0, 1'b0, 1'b0);
        send(0, 1023, 1, 1'b0, 1'b0);
        idle(4);
        check("b2b_count", n_cap, 1568);
        check("b2b_f2_tl", int'(cap_win[784][7:0]), 1);
        check("b2b_f2_latency", cap_acc[784], 1024 + 133);
        check("b2b_fd_count", fd_cnt, 2);
        check("b2b_leftover", exp_q.size(), 0);

        // Restart with in_sof at pixel (10,7), then a full frame.
        do_reset();
        push_part(171, 0);
        push_part(784, 0);
        send(0, 326, 0, 1'b0, 1'b0);
        send(0, 1023, 0, 1'b1, 1'b0);
        idle(4);
        check("sof_count", n_cap, 171 + 784);
        check("sof_restart_latency", cap_acc[171], 327 + 133);
        check("sof_restart_tl", int'(cap_win[171][7:0]), 0);
        check("sof_fd_count", fd_cnt, 1);
        check("sof_leftover", exp_q.size(), 0);

        // Reset pulsed while pixel (15,15) is next.
        do_reset();
        push_part(319, 0);
        send(0, 494, 0, 1'b0, 1'b0);
        check("pre_rst_valid_high", int'(out_valid), 1);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_window_zero", int'(out_window == '0), 1);
        check("midrst_coords", int'({out_row, out_col}), 0);
        check("midrst_seen", n_cap, 318);
        check("midrst_pending", exp_q.size(), 1);
        @(posedge clk);
        #1;
        check("midrst_hold_valid", int'(out_valid), 0);
        check("midrst_hold_window", int'(out_window == '0), 1);
        rst = 1'b1;
        clear_stats();
        push_part(784, 0);
        send(0, 1023, 0, 1'b0, 1'b0);
        idle(4);
        check("postrst_count", n_cap, 784);
        check("postrst_latency", cap_acc[0], 133);
        check("postrst_tl", int'(cap_win[0][7:0]), 0);
        check("postrst_leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator between the pixel source and the C1 convolution stage of the LeNet-5 pipeline. Consumes a raster-order pixel stream (one pixel per accepted cycle, row-major, top-left first) and emits every valid K×K window of the image, one window per cycle, as a flat vector. It buffers K-1 full image rows internally, so C1 sees complete receptive fields without re-reading the image.

## Interface
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in pixels
- K, 5, kernel (window) edge length
- PIXELWIDTH, 8, bits per pixel
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_pixel is valid this cycle
- in_sof  in  1  start-of-frame; meaningful only with in_valid; marks the pixel as (row 0, col 0)
- in_pixel  in  PIXELWIDTH  pixel data
- out_valid  out  1  out_window holds a new window
- out_window  out  K*K*PIXELWIDTH  window; element (r,c) at bits [(r*K+c)*PIXELWIDTH +: PIXELWIDTH], (0,0) = top-left
- out_row, out_col  out  $clog2(IMG_H), $clog2(IMG_W)  window top-left coordinates
- frame_done  out  1  pulses with the last window of a frame

## Operation
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next accepted pixel; they advance only on in_valid. col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1), both wrap to 0.
- in_valid && in_sof: the pixel is taken as (0,0) regardless of the counters. Partial windows from an aborted frame are never emitted. in_sof without in_valid is ignored.
- Storage: K-1 row delay lines of depth IMG_W plus a K×K window register array. On each accepted pixel, every window row shifts left one column. The new rightmost column is filled from the delay-line taps (oldest row at r=0) and in_pixel (r=K-1).
- States: PRIME (row < K-1) and ACTIVE (row ≥ K-1).
  - PRIME→ACTIVE when the last pixel of row K-2 is accepted.
  - ACTIVE→PRIME on frame wrap or in_sof.
- A window is emitted for an accepted pixel at (row, col) iff state is ACTIVE and col ≥ K-1. The emitted window has top-left (row-K+1, col-K+1).
- Windows per frame: (IMG_H-K+1)×(IMG_W-K+1), i.e. 784 at defaults. Windows never straddle a row wrap.
- frame_done is asserted with the window whose pixel is (IMG_H-1, IMG_W-1).
- There is no backpressure. The downstream stage accepts every out_valid cycle.
- Reset values:
  - out_valid, frame_done = 0; out_window = 0; out_row, out_col = 0.
  - Counters = 0, state = PRIME.
  - Delay-line contents are not reset; they are never visible before being overwritten.

## Timing
- Latency: out_valid rises exactly one clock after the accepting edge of the completing pixel. Data and coordinates are registered in the same cycle.
- out_valid and frame_done are single-cycle pulses per window. Back-to-back windows are allowed on consecutive cycles.
- Gaps in in_valid freeze all state. The window sequence is identical with or without gaps.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). After release, the first accepted pixel is (0,0).
- Back-to-back frames (no gap, no in_sof) are supported. The first window of frame N+1 appears K-1 rows plus K-1 pixels after its first pixel.

## Structure
- Shared package lenet_pkg holds:
  - IMG_W, IMG_H, K, PIXELWIDTH defaults
  - the window-slice index helper (r*K+c)*PIXELWIDTH
  - the state enum {PRIME, ACTIVE}
- Sub-module line_delay: a single IMG_W-deep, PIXELWIDTH-wide shift/circular delay line with enable. It is instantiated K-1 times and chained.

## Test plan
- Ramp frame, pixel(r,c) = (r*32+c) mod 256, continuous in_valid:
  - first out_valid one cycle after pixel 132 is accepted, with (0,0)=0x00, (4,4)=0x84, out_row=out_col=0;
  - exactly 784 windows;
  - last window (27,27): top-left 0x7B, bottom-right 0xFF, frame_done=1 on that cycle only.
- Same ramp with pseudo-random in_valid duty cycle of 30%: window contents and order bit-identical to the continuous run; no out_valid during gaps.
- Two back-to-back frames, second frame = ramp + 1: 1568 windows total; the first window of frame 2 has (0,0)=0x01 and no stale frame-1 data.
- in_sof asserted at pixel (10,7) of frame 1, followed by a full ramp frame: no window emitted for rows of the aborted frame after the restart; the following frame yields exactly 784 correct windows.
- rst pulsed low at pixel (15,15):
  - out_valid and out_window read 0 during reset;
  - the restarted ramp frame produces first window (0,0)=0x00 after pixel 132, and 784 windows.
- Edge check of windows per row at defaults: out_col runs 0..27 then returns to 0 with out_row+1, and no window has out_col > 27.
